// File: rtl/edge_to_level_if.sv
// Event link from an edge detector into edge_to_level, plus the rebuilt
// level and its status. The master drives events, the slave rebuilds the level.
interface edge_to_level_if;
    logic        rise;
    logic        down;
    logic        clr;
    logic        level;
    logic        busy;
    logic        pend;
    logic        err_dup;
    logic        err_both;
    logic        err_short;
    logic [15:0] toggle_cnt;

    modport master (
        output rise, down, clr,
        input  level, busy, pend, err_dup, err_both, err_short, toggle_cnt
    );

    modport slave (
        input  rise, down, clr,
        output level, busy, pend, err_dup, err_both, err_short, toggle_cnt
    );
endinterface

// File: rtl/edge_to_level.sv
// Rebuilds a level from rise/down event pulses. Every toggle is followed by
// a minimum hold time. One event arriving during a hold is queued and applied
// when the hold expires. Illegal sequences raise sticky error flags.
module edge_to_level #(
    parameter int MIN_HOLD   = 2,
    parameter int CNT_W      = 4,
    parameter bit INIT_LEVEL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    edge_to_level_if.slave  bus
);

    typedef enum logic [1:0] {
        STEADY    = 2'd0,
        HOLD      = 2'd1,
        HOLD_PEND = 2'd2
    } state_t;

    // Counter value loaded on each toggle. It counts the cycles the new level
    // must stay put after the toggle cycle itself.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD - 1);
    // With a one-cycle hold the counter is never loaded nonzero, so HOLD is skipped.
    localparam bit               LONG_HOLD = (MIN_HOLD > 1);

    if (MIN_HOLD < 1 || MIN_HOLD > (2 ** CNT_W)) begin : g_bad_hold
        $error("edge_to_level: MIN_HOLD must be within 1..2**CNT_W");
    end

    state_t           state_q, state_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] hold_q, hold_d, hold_dec;
    logic             pend_q, pend_d;
    logic             pend_lvl_q, pend_lvl_d;
    logic             err_dup_q, err_dup_d;
    logic             err_both_q, err_both_d;
    logic             err_short_q, err_short_d;
    logic [15:0]      toggle_q, toggle_d;

    logic target;
    logic single;
    logic both;
    logic legal;
    logic dup;
    logic cancel;

    // Classify the incoming pulse against the level the link is heading to.
    // A queued event already defines that level, so it is the reference.
    assign both     = bus.rise & bus.down;
    assign single   = bus.rise ^ bus.down;
    assign target   = pend_q ? pend_lvl_q : level_q;
    assign legal    = single & (bus.rise != target);
    assign dup      = single & (bus.rise == target);
    assign hold_dec = (hold_q != '0) ? hold_q - 1'b1 : '0;

    // State and datapath registers. Reset drops any queued event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STEADY;
            level_q     <= INIT_LEVEL;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            pend_lvl_q  <= 1'b0;
            err_dup_q   <= 1'b0;
            err_both_q  <= 1'b0;
            err_short_q <= 1'b0;
            toggle_q    <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            pend_lvl_q  <= pend_lvl_d;
            err_dup_q   <= err_dup_d;
            err_both_q  <= err_both_d;
            err_short_q <= err_short_d;
            toggle_q    <= toggle_d;
        end
    end

    // Next-state logic: apply, queue, cancel or expire based on the hold state.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        hold_d     = hold_dec;
        pend_d     = pend_q;
        pend_lvl_d = pend_lvl_q;
        toggle_d   = toggle_q;
        cancel     = 1'b0;

        unique case (state_q)
            STEADY: begin
                // Nothing running: a legal pulse lands on the next edge.
                if (legal) begin
                    level_d  = bus.rise;
                    hold_d   = HOLD_LOAD;
                    toggle_d = toggle_q + 16'd1;
                    state_d  = LONG_HOLD ? HOLD : STEADY;
                end
            end

            HOLD: begin
                // Level is frozen: park a legal pulse until the hold runs out.
                if (legal) begin
                    pend_d     = 1'b1;
                    pend_lvl_d = bus.rise;
                    state_d    = HOLD_PEND;
                end else if (hold_dec == '0) begin
                    state_d = STEADY;
                end
            end

            HOLD_PEND: begin
                // An opposite pulse kills the queued one, and wins over expiry.
                if (legal) begin
                    pend_d  = 1'b0;
                    cancel  = 1'b1;
                    state_d = (hold_dec != '0) ? HOLD : STEADY;
                end else if (hold_q == '0) begin
                    level_d  = pend_lvl_q;
                    pend_d   = 1'b0;
                    hold_d   = HOLD_LOAD;
                    toggle_d = toggle_q + 16'd1;
                    state_d  = LONG_HOLD ? HOLD : STEADY;
                end
            end

            default: begin
                state_d = STEADY;
            end
        endcase

        // Sticky flags: clr drops them, but a fresh error in the same cycle wins.
        err_dup_d   = (err_dup_q   & ~bus.clr) | dup;
        err_both_d  = (err_both_q  & ~bus.clr) | both;
        err_short_d = (err_short_q & ~bus.clr) | cancel;
    end

    assign bus.level      = level_q;
    assign bus.busy       = (hold_q != '0);
    assign bus.pend       = pend_q;
    assign bus.err_dup    = err_dup_q;
    assign bus.err_both   = err_both_q;
    assign bus.err_short  = err_short_q;
    assign bus.toggle_cnt = toggle_q;

endmodule

// File: tb/tb_edge_to_level.sv
// Drives four edge_to_level instances with different hold lengths and initial
// levels from one event stream. Expected outputs come from a behavioural model.
// They are queued on every issued cycle and compared by an independent monitor.
module tb_edge_to_level;

    localparam int NI = 4;

    typedef struct packed {
        logic        level;
        logic        busy;
        logic        pend;
        logic        err_dup;
        logic        err_both;
        logic        err_short;
        logic [15:0] toggles;
    } obs_t;

    typedef obs_t [NI-1:0] quad_t;

    logic clk;
    logic rst_n;
    logic rise;
    logic down;
    logic clr;

    obs_t  act [NI];
    quad_t exp_q[$];

    int n_pass;
    int n_total;
    int cyc_n;

    edge_to_level_if bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int MH = (g == 0) ? 3 : (g == 1) ? 4 : (g == 2) ? 1 : 16;
        localparam bit IL = (g == 2);

        edge_to_level #(
            .MIN_HOLD   (MH),
            .CNT_W      (4),
            .INIT_LEVEL (IL)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g])
        );

        assign bus[g].rise = rise;
        assign bus[g].down = down;
        assign bus[g].clr  = clr;
        assign act[g] = {bus[g].level, bus[g].busy, bus[g].pend, bus[g].err_dup,
                         bus[g].err_both, bus[g].err_short, bus[g].toggle_cnt};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int m_lvl  [NI];
    int m_hold [NI];
    int m_pval [NI];
    int m_tog  [NI];
    bit m_pend [NI];
    bit m_ed   [NI];
    bit m_eb   [NI];
    bit m_es   [NI];

    function automatic int mh(input int i);
        case (i)
            0:       return 3;
            1:       return 4;
            2:       return 1;
            default: return 16;
        endcase
    endfunction

    function automatic bit init_lvl(input int i);
        return (i == 2);
    endfunction

    function automatic void model_reset(input int i);
        m_lvl[i]  = int'(init_lvl(i));
        m_hold[i] = 0;
        m_pval[i] = 0;
        m_tog[i]  = 0;
        m_pend[i] = 1'b0;
        m_ed[i]   = 1'b0;
        m_eb[i]   = 1'b0;
        m_es[i]   = 1'b0;
    endfunction

    // One clock of the link: what the level becomes given this cycle's pulses.
    function automatic void model_step(input int i, input bit r, input bit d, input bit c);
        int tgt;
        bit is_dup;
        bit is_both;
        bit is_cancel;
        bit is_legal;
        tgt       = m_pend[i] ? m_pval[i] : m_lvl[i];
        is_dup    = 1'b0;
        is_both   = 1'b0;
        is_cancel = 1'b0;
        is_legal  = 1'b0;
        if (r && d) is_both = 1'b1;
        else if (r || d) begin
            if (int'(r) == tgt) is_dup = 1'b1;
            else is_legal = 1'b1;
        end

        if (is_legal && m_pend[i]) begin
            m_pend[i] = 1'b0;
            is_cancel = 1'b1;
            if (m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
        end else if (is_legal && m_hold[i] == 0) begin
            m_lvl[i]  = int'(r);
            m_hold[i] = mh(i) - 1;
            m_tog[i]  = (m_tog[i] + 1) % 65536;
        end else if (is_legal) begin
            m_pend[i] = 1'b1;
            m_pval[i] = int'(r);
            m_hold[i] = m_hold[i] - 1;
        end else if (m_pend[i] && m_hold[i] == 0) begin
            m_lvl[i]  = m_pval[i];
            m_pend[i] = 1'b0;
            m_hold[i] = mh(i) - 1;
            m_tog[i]  = (m_tog[i] + 1) % 65536;
        end else if (m_hold[i] > 0) begin
            m_hold[i] = m_hold[i] - 1;
        end

        m_ed[i] = (m_ed[i] && !c) || is_dup;
        m_eb[i] = (m_eb[i] && !c) || is_both;
        m_es[i] = (m_es[i] && !c) || is_cancel;
    endfunction

    function automatic obs_t model_obs(input int i);
        obs_t o;
        o.level     = (m_lvl[i] != 0);
        o.busy      = (m_hold[i] != 0);
        o.pend      = m_pend[i];
        o.err_dup   = m_ed[i];
        o.err_both  = m_eb[i];
        o.err_short = m_es[i];
        o.toggles   = 16'(m_tog[i]);
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Monitor: after each active edge, compare every instance with the queued prediction.
    initial begin
        quad_t e;
        cyc_n = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NI; i++)
                    check($sformatf("obs u%0d cyc%0d", i, cyc_n), 32'(act[i]), 32'(e[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit d, input bit c);
        quad_t e;
        @(negedge clk);
        rise = r;
        down = d;
        clr  = c;
        for (int i = 0; i < NI; i++) begin
            model_step(i, r, d, c);
            e[i] = model_obs(i);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle: outputs must already be at reset values 1 ns later.
    task automatic do_reset();
        obs_t r;
        @(negedge clk);
        rise  = 1'b0;
        down  = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            r       = '0;
            r.level = init_lvl(i);
            check($sformatf("reset u%0d", i), 32'(act[i]), 32'(r));
            model_reset(i);
        end
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int p;
        bit r;
        bit d;
        bit c;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        rise    = 1'b0;
        down    = 1'b0;
        clr     = 1'b0;

        do_reset();
        idle(20);

        // single rise, then rise followed by a queued down
        idle(4);
        cyc(1'b1, 1'b0, 1'b0);
        idle(6);
        cyc(1'b0, 1'b1, 1'b0);
        idle(20);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        idle(20);

        // queued event cancelled by its opposite
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(20);

        // error flags, clearing, and set-wins-over-clear
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        idle(2);
        cyc(1'b1, 1'b0, 1'b1);
        idle(20);

        // build hold + pending on the MIN_HOLD=3 instance, then reset on top of it
        cyc(1'b0, 1'b1, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("pend before reset", 32'(act[0].pend), 32'd1);
        check("busy before reset", 32'(act[0].busy), 32'd1);
        do_reset();

        // MIN_HOLD=1 instance starts high: alternating pulses toggle every cycle
        for (int k = 0; k < 10; k++) cyc((k % 2) == 1, (k % 2) == 0, 1'b0);
        @(posedge clk);
        #2;
        check("alt toggles u2", 32'(act[2].toggles), 32'd10);
        idle(20);

        // randomized traffic with sporadic clears and resets
        for (int k = 0; k < 3000; k++) begin
            p = $urandom_range(0, 99);
            r = (p < 30) || (p >= 60 && p < 66);
            d = (p >= 30 && p < 66);
            c = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 999) < 3) do_reset();
            else cyc(r, d, c);
        end

        @(negedge clk);
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
